// File: rtl/dct8x8_core.sv
// dct8x8_core: forward 8x8 2-D DCT, Y = A*X*A^T / 65536.
// One block is loaded in raster order. It is transformed by a single shared
// multiply-accumulate unit: a row pass into T, then a column pass into Y.
// The result is streamed out in raster order.
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds data stable until then.
module dct8x8_core #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [6:0]        out_index,
    output logic              busy
);

    typedef enum logic [1:0] {LOAD, PASS1, PASS2, DRAIN} state_t;

    // 256-scaled DCT basis, row-major (row = frequency, column = sample)
    localparam logic signed [9:0] A_ROM [64] = '{
        10'sd90,  10'sd90,   10'sd90,   10'sd90,   10'sd90,   10'sd90,   10'sd90,   10'sd90,
        10'sd125, 10'sd106,  10'sd71,   10'sd24,  -10'sd24,  -10'sd71,  -10'sd106, -10'sd125,
        10'sd118, 10'sd48,  -10'sd48,  -10'sd118, -10'sd118, -10'sd48,   10'sd48,   10'sd118,
        10'sd106, -10'sd24, -10'sd125, -10'sd71,   10'sd71,   10'sd125,  10'sd24,  -10'sd106,
        10'sd90, -10'sd90,  -10'sd90,   10'sd90,   10'sd90,  -10'sd90,  -10'sd90,   10'sd90,
        10'sd71, -10'sd125,  10'sd24,   10'sd106, -10'sd106, -10'sd24,   10'sd125, -10'sd71,
        10'sd48, -10'sd118,  10'sd118, -10'sd48,  -10'sd48,   10'sd118, -10'sd118,  10'sd48,
        10'sd24, -10'sd71,   10'sd106, -10'sd125,  10'sd125, -10'sd106,  10'sd71,  -10'sd24
    };

    state_t state_q, state_d;
    logic [5:0]  cnt_q;     // load sample count in LOAD, output index in DRAIN
    logic [8:0]  step_q;    // {r, c, k} loop position in PASS1/PASS2
    logic signed [33:0] acc_q;

    logic [DATA_W-1:0] x_mem [64];
    logic signed [21:0] t_mem [64];
    logic [DATA_W-1:0] y_mem [64];

    logic [2:0] k, c, r;
    logic [5:0] a_idx;
    logic signed [9:0]  a_val;
    logic signed [21:0] b_val;
    logic signed [31:0] prod;
    logic signed [33:0] sum, sum_adj, quo;
    logic ovf;
    logic [DATA_W-1:0] sat;
    logic in_fire, out_fire, last_step, in_pass;

    assign k = step_q[2:0];
    assign c = step_q[5:3];
    assign r = step_q[8:6];
    assign in_pass   = (state_q == PASS1) || (state_q == PASS2);
    assign last_step = (step_q == 9'd511);
    assign in_fire   = (state_q == LOAD) && in_valid;
    assign out_fire  = (state_q == DRAIN) && out_ready;

    // Shared MAC operand selection, divide-by-65536 toward zero, and saturation
    always_comb begin
        a_idx = (state_q == PASS1) ? {c, k} : {r, k};
        a_val = A_ROM[a_idx];
        if (state_q == PASS1) begin
            b_val = {{(22-DATA_W){x_mem[{r, k}][DATA_W-1]}}, x_mem[{r, k}]};
        end else begin
            b_val = t_mem[{k, c}];
        end
        prod    = a_val * b_val;
        sum     = acc_q + {{2{prod[31]}}, prod};
        // Bias negatives so the arithmetic shift truncates toward zero
        sum_adj = sum[33] ? (sum + 34'sd65535) : sum;
        quo     = sum_adj >>> 16;
        ovf     = !((&quo[33:DATA_W-1]) || (~|quo[33:DATA_W-1]));
        sat     = ovf ? {quo[33], {(DATA_W-1){~quo[33]}}} : quo[DATA_W-1:0];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (in_fire && cnt_q == 6'd63) state_d = PASS1;
            PASS1:   if (last_step) state_d = PASS2;
            PASS2:   if (last_step) state_d = DRAIN;
            DRAIN:   if (out_fire && cnt_q == 6'd63) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // State, counters and accumulator; reset abandons any partial block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            step_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire || out_fire) cnt_q <= cnt_q + 6'd1;
            step_q  <= in_pass ? step_q + 9'd1 : 9'd0;
            acc_q   <= (in_pass && k != 3'd7) ? sum : 34'sd0;
        end
    end

    // Buffer writes: samples in LOAD, row results in PASS1, coefficients in PASS2
    always_ff @(posedge clk) begin
        if (in_fire) x_mem[cnt_q] <= in_data;
        if (state_q == PASS1 && k == 3'd7) t_mem[{r, c}] <= sum[21:0];
        if (state_q == PASS2 && k == 3'd7) y_mem[{r, c}] <= sat;
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != LOAD);
    assign out_data  = out_valid ? y_mem[cnt_q] : '0;
    assign out_index = out_valid ? {1'b0, cnt_q} : 7'd0;

endmodule

// File: doc/dct8x8_core.md
# dct8x8_core

Forward 8x8 2-D DCT engine that sits directly upstream of the IDCT stage. It accepts one level-shifted 8x8 sample block in raster order and computes Y = A·X·Aᵀ / 65536 with a single time-shared multiply-accumulate unit. A is the team's 256-scaled DCT basis, the same matrix the IDCT uses. It then streams the 64 coefficients out in raster order, tagged with the coefficient index that the IDCT's array-addressing port expects.

## Interface
- DATA_W, 10, sample and coefficient width (signed two's complement)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data holds a valid sample
- in_ready  out  1  block accepts a sample on this cycle
- in_data  in  DATA_W  signed sample; raster order, index = row*8+col
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  downstream accepts the current coefficient
- out_data  out  DATA_W  signed DCT coefficient, saturated
- out_index  out  7  raster index 0..63 of out_data
- busy  out  1  high in PASS1, PASS2 and DRAIN

## Operation
- Internal storage:
  - X buffer: 64×10b.
  - T buffer: 64×22b signed.
  - Y buffer: 64×10b.
  - A ROM: 64×10b signed, row-major.
    - Row 0: 90 ×8
    - Row 1: 125 106 71 24 -24 -71 -106 -125
    - Row 2: 118 48 -48 -118 -118 -48 48 118
    - Row 3: 106 -24 -125 -71 71 125 24 -106
    - Row 4: 90 -90 -90 90 90 -90 -90 90
    - Row 5: 71 -125 24 106 -106 -24 125 -71
    - Row 6: 48 -118 118 -48 -48 118 -118 48
    - Row 7: 24 -71 106 -125 125 -106 71 -24
- FSM states: LOAD, PASS1, PASS2, DRAIN. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready edge writes X[cnt] and increments cnt.
  - The edge that accepts sample 63 moves to PASS1, cnt←0.
- PASS1 (row transform):
  - Computes T[r][c] = Σk X[r][k]·A[c][k].
  - One MAC per cycle; k innermost, then c, then r.
  - On k=7 the completed sum is written to T and the accumulator clears.
  - Exactly 512 cycles, then PASS2.
- PASS2 (column transform):
  - Computes Y[r][c] = Σk A[r][k]·T[k][c], same loop order, 512 cycles.
  - Accumulator is 34b signed.
  - Result is divided by 65536 with truncation toward zero (signed divide semantics, not an arithmetic shift).
  - Result is then saturated to [-512, 511] and written to Y. Then DRAIN.
- DRAIN:
  - out_valid=1, out_data=Y[idx], out_index=idx.
  - idx advances only on an out_valid&out_ready edge.
  - The handshake at idx=63 returns to LOAD with cnt←0.
  - out_data and out_index hold stable while out_ready=0.
- in_ready=0 outside LOAD. Samples presented outside LOAD are ignored, not queued.
- Width rules:
  - Product 10b×10b → 20b; PASS1 sum of 8 → 22b, no overflow possible.
  - PASS2 product 10b×22b → 32b; sum → 34b, no overflow possible.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_index=0, busy=0.
  - All counters 0, state LOAD.
  - Buffers are not required to reset.
- Reset assertion is asynchronous and takes effect in any state, including mid-pass or mid-drain.
  - A partial block is discarded.
  - After release, the next accepted sample is index 0.
- Throughput in LOAD: one sample per cycle when in_valid is held high; 64 cycles per block minimum.
- Latency: if edge E accepts sample 63, then PASS1 spans E..E+511, PASS2 starts at E+512, and DRAIN starts at E+1024.
  - out_valid is first visible after edge E+1024.
- With out_ready held high, DRAIN takes 64 cycles; in_ready rises after the 64th output handshake edge.
- Minimum block period: 64+1024+64 = 1152 cycles.
- busy rises on edge E and falls on the final DRAIN handshake edge.

## Test plan
- All-zero block, out_ready=1 → 64 outputs all 0; out_index runs 0..63; first out_valid exactly 1024 edges after the last input.
- Constant block 50 → out_data[0]=395 (25920000/65536 truncated); indices 1..63 = 0. Constant -50 → out_data[0]=-395.
- Constant 100 → out_data[0] saturates to 511; constant -100 → -512; all others 0.
- Impulse X[0]=100, rest 0 → out_data[0]=12, out_data[9]=23 (125·125·100/65536), out_data[1]=17 (90·125·100/65536); every output matches the truncated A[r][0]·A[c][0]·100/65536.
- Backpressure: toggle out_ready 1,0,0,1,… during DRAIN → data and index hold while stalled; no index skipped or duplicated; in_ready stays 0 until index 63 handshakes. Inputs driven during busy are ignored.
- Reset mid-PASS2 (about 300 cycles in) → outputs return to reset values immediately. A fresh constant-50 block then yields 395 at index 0 with no residue from the aborted block.
